chroma_key_calibrator: RTL and testbench
========================================

Name: chroma_key_calibrator

Overview:
- Inverse of the chroma-key matcher: it derives thresholds from pixels instead of testing pixels against thresholds.
- On request, samples a fixed 2^WIN_LOG2 x 2^WIN_LOG2 window of HSV pixels in one frame and computes the mean H, S and V.
- Publishes the means as new nominal thresholds, with a one-cycle valid pulse.
- Sits beside the chroma-key matcher, fed by the same HSV pixel stream and VGA counters. The user holds the green screen in the window and presses a button.

Parameters:
- WIN_X0, 480, left column of the sampling window (hcount units).
- WIN_Y0, 352, top row of the sampling window (vcount units).
- WIN_LOG2, 4, log2 of window side; 4 gives 16x16 = 256 samples.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  synchronous active-low reset.
- vsync  in  1  VGA vsync; active-low pulse.
- hcount  in  11  column of hsv_in.
- vcount  in  10  row of hsv_in.
- hsv_in  in  24  {H[23:16], S[15:8], V[7:0]}, aligned with hcount/vcount.
- calib_start  in  1  single-cycle request, already debounced.
- h_nom  out  8  calibrated H nominal.
- s_nom  out  8  calibrated S nominal.
- v_nom  out  8  calibrated V nominal.
- range_out  out  8  suggested +/- range.
- busy  out  1  high in ARM/SAMPLE/DONE.
- cal_valid  out  1  one-cycle pulse when outputs update.
- cal_err  out  1  one-cycle pulse on aborted calibration.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state IDLE, accumulators and sample counter 0.
  - h_nom=85, s_nom=94, v_nom=202, range_out=50.
  - busy=0, cal_valid=0, cal_err=0.
- vsync_fall: registered falling edge of vsync (vsync_q=1, vsync=0).
- in_win: hcount in [WIN_X0, WIN_X0+2^WIN_LOG2-1] and vcount in [WIN_Y0, WIN_Y0+2^WIN_LOG2-1].
- FSM:
  - IDLE: calib_start -> ARM.
  - ARM: vsync_fall -> SAMPLE, clearing accumulators and counter.
  - SAMPLE: on each edge with in_win, add H, S and V to their accumulators and increment the counter.
    - The edge that takes the counter to 2^(2*WIN_LOG2) -> DONE.
    - vsync_fall before completion -> IDLE with a 1-cycle cal_err; outputs unchanged.
    - If completion and vsync_fall occur on the same edge, completion wins.
  - DONE: one cycle. Latch h_nom/s_nom/v_nom = accumulator >> (2*WIN_LOG2) (truncating mean), pulse cal_valid, -> IDLE.
- Latency: final window pixel sampled at edge k; new outputs and cal_valid visible after edge k+1; cal_valid high exactly one cycle.
- Widths and arithmetic:
  - Accumulators are 8+2*WIN_LOG2 bits; they cannot overflow.
  - Sample counter is 2*WIN_LOG2+1 bits.
  - Plain arithmetic mean; no hue wrap-around handling.
- calib_start outside IDLE (ARM/SAMPLE/DONE) is ignored; it is not queued.
- Outputs hold their last value until the next cal_valid or reset.
- Reset mid-operation aborts immediately with no cal_err and restores the nominal outputs.

Optional Feature:
- Macro CAL_MINMAX_EN.
- Defined:
  - SAMPLE also tracks running H min and max, initialised to 255/0 on entering SAMPLE.
  - DONE latches range_out = (h_max - h_min) >> 1.
- Undefined:
  - No min/max logic is built; range_out is held at 50.
  - All other behaviour is identical.

Decomposition:
- Shared package holds the nominal constants (H 85, S 94, V 202, RANGE 50), the HSV field slice positions and the FSM state encoding. The chroma-key matcher should reuse the same nominals from it.
- One natural sub-module: cal_window_accum. One instance per channel (H, S, V); each holds an accumulator, clear/enable inputs and a shifted-mean output.
- The FSM, counter, edge detect and min/max tracking stay in the top module.

Test Plan:
- Constant pixel H=100, S=120, V=200; pulse calib_start, then run one frame. Expect h/s/v_nom=100/120/200; cal_valid a single cycle, one edge after the 256th window pixel; busy back to 0.
- Window rows 0-7 at H=0x10 and rows 8-15 at H=0x30, S=V=0x80. Expect h_nom=0x20, s_nom=v_nom=0x80. With CAL_MINMAX_EN, expect range_out=0x10.
- rst_n low for one edge mid-SAMPLE. Expect outputs 85/94/202/50, busy=0, no cal_err, no cal_valid in the following frame.
- Drive hcount so the window is never reached for a full frame, with vsync toggling. Expect cal_err one cycle at the second vsync_fall; outputs unchanged; state IDLE.
- Pulse calib_start again during SAMPLE. Expect no restart and exactly one cal_valid, with the first frame's means.
- With CAL_MINMAX_EN, H ramps 60..110 across the window. Expect range_out=25. Without the macro, range_out=50.

Source files
------------

// File: rtl/chroma_key_calibrator_pkg.sv
// Shared constants for the chroma-key calibrator and matcher: nominal thresholds,
// HSV field positions and the calibrator FSM encoding.
package chroma_key_calibrator_pkg;

  localparam int PIX_W  = 8;
  localparam int HSV_W  = 3 * PIX_W;

  localparam logic [PIX_W-1:0] H_NOM     = 8'd85;
  localparam logic [PIX_W-1:0] S_NOM     = 8'd94;
  localparam logic [PIX_W-1:0] V_NOM     = 8'd202;
  localparam logic [PIX_W-1:0] RANGE_NOM = 8'd50;

  localparam int H_MSB = 23;
  localparam int H_LSB = 16;
  localparam int S_MSB = 15;
  localparam int S_LSB = 8;
  localparam int V_MSB = 7;
  localparam int V_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } cal_state_t;

endpackage

// File: rtl/chroma_key_calibrator_if.sv
// Pixel-stream inputs and calibration results of the chroma-key calibrator.
interface chroma_key_calibrator_if;
  import chroma_key_calibrator_pkg::*;

  logic             vsync;
  logic [10:0]      hcount;
  logic [9:0]       vcount;
  logic [HSV_W-1:0] hsv_in;
  logic             calib_start;
  logic [PIX_W-1:0] h_nom;
  logic [PIX_W-1:0] s_nom;
  logic [PIX_W-1:0] v_nom;
  logic [PIX_W-1:0] range_out;
  logic             busy;
  logic             cal_valid;
  logic             cal_err;

  modport master (
    output vsync, hcount, vcount, hsv_in, calib_start,
    input  h_nom, s_nom, v_nom, range_out, busy, cal_valid, cal_err
  );

  modport slave (
    input  vsync, hcount, vcount, hsv_in, calib_start,
    output h_nom, s_nom, v_nom, range_out, busy, cal_valid, cal_err
  );

endinterface

// File: rtl/chroma_key_calibrator_cal_window_accum.sv
// One colour channel of the calibration window: sums samples and exposes the
// truncated mean over 2^(2*WIN_LOG2) samples.
module cal_window_accum
  import chroma_key_calibrator_pkg::*;
#(
  parameter int WIN_LOG2 = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] mean
);

  localparam int ACC_W = PIX_W + 2 * WIN_LOG2;

  logic [ACC_W-1:0] acc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(din);
    end
  end

  // Dividing by the sample count is just taking the top byte.
  assign mean = acc[ACC_W-1 -: PIX_W];

endmodule

// File: rtl/chroma_key_calibrator.sv
// Chroma-key calibrator: averages HSV over a fixed window for one frame and
// publishes the means as nominal thresholds. `define CAL_MINMAX_EN adds H min/max range tracking.
module chroma_key_calibrator
  import chroma_key_calibrator_pkg::*;
#(
  parameter int WIN_X0   = 480,
  parameter int WIN_Y0   = 352,
  parameter int WIN_LOG2 = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  chroma_key_calibrator_if.slave  bus
);

  localparam int              CNT_W    = 2 * WIN_LOG2 + 1;
  localparam int              WIN_SIDE = 1 << WIN_LOG2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << (2 * WIN_LOG2)) - 1);

  cal_state_t       state, state_nx;
  logic             vsync_q;
  logic             vsync_fall;
  logic             in_win;
  logic             acc_clr;
  logic             acc_en;
  logic             err_nx;
  logic [CNT_W-1:0] cnt;
  logic [PIX_W-1:0] h_pix, s_pix, v_pix;
  logic [PIX_W-1:0] h_mean, s_mean, v_mean;
  logic [PIX_W-1:0] h_nom_q, s_nom_q, v_nom_q;
  logic             cal_valid_q, cal_err_q;

  assign h_pix = bus.hsv_in[H_MSB:H_LSB];
  assign s_pix = bus.hsv_in[S_MSB:S_LSB];
  assign v_pix = bus.hsv_in[V_MSB:V_LSB];

  assign vsync_fall = vsync_q & ~bus.vsync;
  assign in_win = (int'(bus.hcount) >= WIN_X0) && (int'(bus.hcount) <= WIN_X0 + WIN_SIDE - 1) &&
                  (int'(bus.vcount) >= WIN_Y0) && (int'(bus.vcount) <= WIN_Y0 + WIN_SIDE - 1);

  always_comb begin
    state_nx = state;
    acc_clr  = 1'b0;
    acc_en   = 1'b0;
    err_nx   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.calib_start) state_nx = ST_ARM;
      end
      ST_ARM: begin
        if (vsync_fall) begin
          state_nx = ST_SAMPLE;
          acc_clr  = 1'b1;
        end
      end
      ST_SAMPLE: begin
        acc_en = in_win;
        // A completing sample beats a simultaneous frame boundary.
        if (in_win && (cnt == CNT_LAST)) begin
          state_nx = ST_DONE;
        end else if (vsync_fall) begin
          state_nx = ST_IDLE;
          err_nx   = 1'b1;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      vsync_q     <= 1'b1;
      cnt         <= '0;
      h_nom_q     <= H_NOM;
      s_nom_q     <= S_NOM;
      v_nom_q     <= V_NOM;
      cal_valid_q <= 1'b0;
      cal_err_q   <= 1'b0;
    end else begin
      state       <= state_nx;
      vsync_q     <= bus.vsync;
      cal_err_q   <= err_nx;
      cal_valid_q <= (state == ST_DONE);
      if (acc_clr) begin
        cnt <= '0;
      end else if (acc_en) begin
        cnt <= cnt + 1'b1;
      end
      if (state == ST_DONE) begin
        h_nom_q <= h_mean;
        s_nom_q <= s_mean;
        v_nom_q <= v_mean;
      end
    end
  end

  cal_window_accum #(.WIN_LOG2(WIN_LOG2)) u_acc_h (
    .clk(clk), .rst_n(rst_n), .clr(acc_clr), .en(acc_en), .din(h_pix), .mean(h_mean)
  );
  cal_window_accum #(.WIN_LOG2(WIN_LOG2)) u_acc_s (
    .clk(clk), .rst_n(rst_n), .clr(acc_clr), .en(acc_en), .din(s_pix), .mean(s_mean)
  );
  cal_window_accum #(.WIN_LOG2(WIN_LOG2)) u_acc_v (
    .clk(clk), .rst_n(rst_n), .clr(acc_clr), .en(acc_en), .din(v_pix), .mean(v_mean)
  );

`ifdef CAL_MINMAX_EN
  logic [PIX_W-1:0] h_min, h_max, range_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_min   <= 8'hFF;
      h_max   <= 8'h00;
      range_q <= RANGE_NOM;
    end else begin
      if (acc_clr) begin
        h_min <= 8'hFF;
        h_max <= 8'h00;
      end else if (acc_en) begin
        if (h_pix < h_min) h_min <= h_pix;
        if (h_pix > h_max) h_max <= h_pix;
      end
      // Half the observed hue spread becomes the suggested +/- range.
      if (state == ST_DONE) range_q <= 8'(h_max - h_min) >> 1;
    end
  end

  assign bus.range_out = range_q;
`else
  assign bus.range_out = RANGE_NOM;
`endif

  assign bus.h_nom     = h_nom_q;
  assign bus.s_nom     = s_nom_q;
  assign bus.v_nom     = v_nom_q;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.cal_valid = cal_valid_q;
  assign bus.cal_err   = cal_err_q;

endmodule

// File: tb/tb_chroma_key_calibrator.sv
// Bench for chroma_key_calibrator: table of calibration frames checked through a
// scoreboard, plus hand sequences for restart, abort and mid-frame reset.
module tb_chroma_key_calibrator;
  import chroma_key_calibrator_pkg::*;

  localparam int WX = 480;
  localparam int WY = 352;
`ifdef CAL_MINMAX_EN
  localparam bit MINMAX = 1'b1;
`else
  localparam bit MINMAX = 1'b0;
`endif

  typedef struct {
    int         mode;
    logic [7:0] h;
    logic [7:0] s;
    logic [7:0] v;
    logic [7:0] rng;
  } vec_t;

  typedef struct {
    logic [7:0] h;
    logic [7:0] s;
    logic [7:0] v;
    logic [7:0] rng;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  chroma_key_calibrator_if bus();

  chroma_key_calibrator #(.WIN_X0(WX), .WIN_Y0(WY), .WIN_LOG2(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  exp_t exp_q[$];
  vec_t tv[4];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   n_valid = 0;
  int   n_calerr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [23:0] pix(input int mode, input int r, input int c);
    case (mode)
      0:       return {8'd100, 8'd120, 8'd200};
      1:       return (r < 8) ? 24'h108080 : 24'h308080;
      2:       return {8'(60 + (r * 16 + c) * 50 / 255), 8'(r * 16), 8'(c * 16)};
      default: return {8'(r * c), 8'(r * 13 + c * 7), 8'(255 - r - c)};
    endcase
  endfunction

  function automatic vec_t model(input int mode);
    int sh = 0, ss = 0, sv = 0, mn = 255, mx = 0, hv;
    logic [23:0] p;
    vec_t m;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        p  = pix(mode, r, c);
        hv = int'(p[23:16]);
        sh += hv;
        ss += int'(p[15:8]);
        sv += int'(p[7:0]);
        if (hv < mn) mn = hv;
        if (hv > mx) mx = hv;
      end
    end
    m.mode = mode;
    m.h    = 8'(sh / 256);
    m.s    = 8'(ss / 256);
    m.v    = 8'(sv / 256);
    m.rng  = MINMAX ? 8'((mx - mn) / 2) : 8'd50;
    return m;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard side: pop and compare on every cal_valid, watch pulse widths.
  initial begin
    logic pv, pe;
    exp_t e;
    pv = 1'b0;
    pe = 1'b0;
    forever begin
      @(negedge clk);
      if (pv) check("cal_valid one cycle", bus.cal_valid, 0);
      if (pe) check("cal_err one cycle", bus.cal_err, 0);
      if (bus.cal_valid) begin
        n_valid++;
        check("cal_valid expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("h_nom", bus.h_nom, e.h);
          check("s_nom", bus.s_nom, e.s);
          check("v_nom", bus.v_nom, e.v);
          check("range_out", bus.range_out, e.rng);
          check("cal_valid cycle", cyc, e.cyc);
          check("busy at cal_valid", bus.busy, 0);
        end
      end
      if (bus.cal_err) n_calerr++;
      pv = bus.cal_valid;
      pe = bus.cal_err;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    bus.calib_start = 1'b1;
    @(negedge clk);
    bus.calib_start = 1'b0;
    @(negedge clk);
  endtask

  // act: 1 = pulse calib_start, 2 = pulse reset, at the start of row act_row.
  task automatic run_frame(input int mode, input bit offwin, input int act_row, input int act,
                           input bit push, input vec_t e);
    int   n;
    bit   inw;
    exp_t x;
    n = 0;
    bus.hcount = '0;
    bus.vcount = '0;
    bus.hsv_in = '0;
    bus.vsync  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.vsync = 1'b1;
    @(negedge clk);
    for (int r = -2; r < 18; r++) begin
      for (int c = -2; c < 18; c++) begin
        bus.hcount      = 11'(WX + c + (offwin ? 200 : 0));
        bus.vcount      = 10'(WY + r);
        inw             = !offwin && r >= 0 && r < 16 && c >= 0 && c < 16;
        bus.hsv_in      = inw ? pix(mode, r, c) : 24'hFFFFFF;
        bus.calib_start = (r == act_row && c == -2 && act == 1);
        rst_n           = !(r == act_row && c == -2 && act == 2);
        if (inw) begin
          n++;
          if (n == 256 && push) begin
            x.h   = e.h;
            x.s   = e.s;
            x.v   = e.v;
            x.rng = e.rng;
            x.cyc = cyc + 2;
            exp_q.push_back(x);
          end
        end
        @(negedge clk);
      end
    end
    bus.calib_start = 1'b0;
    rst_n           = 1'b1;
    bus.hcount      = '0;
    bus.vcount      = '0;
  endtask

  initial begin
    vec_t m2;
    vec_t none;
    int   nv, ne;
    none = '{0, 8'd0, 8'd0, 8'd0, 8'd0};
    bus.vsync       = 1'b1;
    bus.hcount      = '0;
    bus.vcount      = '0;
    bus.hsv_in      = '0;
    bus.calib_start = 1'b0;
    rst_n           = 1'b0;
    idle(3);
    check("reset h_nom", bus.h_nom, 85);
    check("reset s_nom", bus.s_nom, 94);
    check("reset v_nom", bus.v_nom, 202);
    check("reset range_out", bus.range_out, 50);
    check("reset busy", bus.busy, 0);
    check("reset cal_valid", bus.cal_valid, 0);
    check("reset cal_err", bus.cal_err, 0);
    rst_n = 1'b1;
    idle(2);

    m2    = model(2);
    tv[0] = '{0, 8'd100, 8'd120, 8'd200, MINMAX ? 8'd0 : 8'd50};
    tv[1] = '{1, 8'h20, 8'h80, 8'h80, MINMAX ? 8'h10 : 8'd50};
    tv[2] = '{2, m2.h, 8'd120, 8'd120, MINMAX ? 8'd25 : 8'd50};
    tv[3] = model(3);

    for (int i = 0; i < 4; i++) begin
      pulse_start();
      check("busy after start", bus.busy, 1);
      run_frame(tv[i].mode, 1'b0, -99, 0, 1'b1, tv[i]);
      idle(4);
      check("cal_valid count", n_valid, i + 1);
      check("busy after done", bus.busy, 0);
      check("no cal_err", n_calerr, 0);
    end

    // calib_start during SAMPLE must neither restart nor queue a second run.
    nv = n_valid;
    pulse_start();
    run_frame(1, 1'b0, 5, 1, 1'b1, tv[1]);
    idle(4);
    check("restart one cal_valid", n_valid, nv + 1);
    run_frame(0, 1'b0, -99, 0, 1'b0, none);
    idle(4);
    check("restart not queued", n_valid, nv + 1);
    check("restart busy", bus.busy, 0);

    // Window never reached: second frame boundary aborts with cal_err.
    ne = n_calerr;
    nv = n_valid;
    pulse_start();
    run_frame(0, 1'b1, -99, 0, 1'b0, none);
    check("abort no early err", n_calerr, ne);
    check("abort busy sampling", bus.busy, 1);
    run_frame(0, 1'b1, -99, 0, 1'b0, none);
    idle(4);
    check("abort cal_err", n_calerr, ne + 1);
    check("abort busy", bus.busy, 0);
    check("abort h_nom held", bus.h_nom, tv[1].h);
    check("abort s_nom held", bus.s_nom, tv[1].s);
    check("abort range held", bus.range_out, tv[1].rng);
    check("abort no cal_valid", n_valid, nv);

    // Reset in the middle of sampling.
    ne = n_calerr;
    pulse_start();
    run_frame(0, 1'b0, 5, 2, 1'b0, none);
    idle(2);
    check("midreset h_nom", bus.h_nom, 85);
    check("midreset s_nom", bus.s_nom, 94);
    check("midreset v_nom", bus.v_nom, 202);
    check("midreset range", bus.range_out, 50);
    check("midreset busy", bus.busy, 0);
    check("midreset no cal_err", n_calerr, ne);
    run_frame(0, 1'b0, -99, 0, 1'b0, none);
    idle(4);
    check("midreset no cal_valid", n_valid, nv);

    check("scoreboard drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
